// File: rtl/sha256_msg_sched.sv
// SHA-256 message-schedule generator.
// Takes one 512-bit block as 16 serial 32-bit words (M[0] first) and streams
// out W[0..63] one word per handshake. A 16-word sliding window holds
// W[idx..idx+15]. Each emitted word makes room for the next expanded word,
// so only one sigma/adder datapath is needed and no 64-word store exists.
module sha256_msg_sched #(
  parameter int NUM_ROUNDS = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        blk_valid,
  output logic        blk_ready,
  input  logic [31:0] blk_word,
  output logic        w_valid,
  input  logic        w_ready,
  output logic [31:0] w_word,
  output logic [5:0]  w_idx,
  output logic        w_last,
  output logic        busy
);

  localparam logic [5:0] LAST_IDX     = 6'(NUM_ROUNDS - 1);
  localparam logic [5:0] PRE_LAST_IDX = 6'(NUM_ROUNDS - 2);

  typedef enum logic {
    LOAD,
    EMIT
  } state_t;

  state_t      state;
  logic [3:0]  load_cnt;
  logic [5:0]  idx;
  logic [31:0] win [16];

  logic        load_fire;
  logic        emit_fire;
  logic [31:0] sig0;
  logic [31:0] sig1;
  logic [31:0] next_word;
  logic [31:0] shift_in;

  // Small sigma functions from the SHA-256 schedule recurrence.
  function automatic logic [31:0] small_sigma0(input logic [31:0] x);
    small_sigma0 = {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] small_sigma1(input logic [31:0] x);
    small_sigma1 = {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  // blk_ready and w_valid are registered and mirror the state, so the
  // handshakes can be qualified directly with them.
  assign load_fire = blk_valid & blk_ready;
  assign emit_fire = w_valid & w_ready;

  // Expansion of the word that enters the window when the oldest one leaves.
  assign sig0      = small_sigma0(win[1]);
  assign sig1      = small_sigma1(win[14]);
  assign next_word = sig1 + win[9] + sig0 + win[0];
  assign shift_in  = (state == LOAD) ? blk_word : next_word;

  assign w_idx = idx;
  assign busy  = (state != LOAD) || (load_cnt != 4'd0);

  // Sliding window: shifts toward win[0] on every accepted input or output
  // word; contents after reset are irrelevant, so the window is not reset.
  always_ff @(posedge clk) begin
    if (load_fire || emit_fire) begin
      for (int i = 0; i < 15; i++) begin
        win[i] <= win[i + 1];
      end
      win[15] <= shift_in;
    end
  end

  // Control FSM with registered handshake flags and output word/index.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= LOAD;
      load_cnt  <= 4'd0;
      idx       <= 6'd0;
      blk_ready <= 1'b1;
      w_valid   <= 1'b0;
      w_word    <= 32'd0;
      w_last    <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          if (load_fire) begin
            load_cnt <= load_cnt + 4'd1;
            if (load_cnt == 4'd15) begin
              state     <= EMIT;
              blk_ready <= 1'b0;
              w_valid   <= 1'b1;
              w_word    <= win[1];
              idx       <= 6'd0;
              w_last    <= 1'b0;
            end
          end
        end
        EMIT: begin
          if (emit_fire) begin
            if (idx == LAST_IDX) begin
              state     <= LOAD;
              load_cnt  <= 4'd0;
              idx       <= 6'd0;
              blk_ready <= 1'b1;
              w_valid   <= 1'b0;
              w_word    <= 32'd0;
              w_last    <= 1'b0;
            end else begin
              idx    <= idx + 6'd1;
              w_word <= win[1];
              w_last <= (idx == PRE_LAST_IDX);
            end
          end
        end
        default: begin
          state     <= LOAD;
          load_cnt  <= 4'd0;
          idx       <= 6'd0;
          blk_ready <= 1'b1;
          w_valid   <= 1'b0;
          w_word    <= 32'd0;
          w_last    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_msg_sched.sv
// Directed testbench for sha256_msg_sched: reset values, the "abc" block,
// an all-ones block, random consumer stalls, sparse loading with blk_valid
// held through emission, and a reset in the middle of emission.
module tb_sha256_msg_sched;

  logic        clk;
  logic        rst;
  logic        blk_valid;
  logic        blk_ready;
  logic [31:0] blk_word;
  logic        w_valid;
  logic        w_ready;
  logic [31:0] w_word;
  logic [5:0]  w_idx;
  logic        w_last;
  logic        busy;

  int errors;
  int checks;

  logic [31:0] msg   [16];
  logic [31:0] ref_w [64];

  sha256_msg_sched #(.NUM_ROUNDS(64)) dut (
    .clk       (clk),
    .rst       (rst),
    .blk_valid (blk_valid),
    .blk_ready (blk_ready),
    .blk_word  (blk_word),
    .w_valid   (w_valid),
    .w_ready   (w_ready),
    .w_word    (w_word),
    .w_idx     (w_idx),
    .w_last    (w_last),
    .busy      (busy)
  );

  // Free-running clock, 10 time-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock and land 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    rotr = (x >> n) | (x << (32 - n));
  endfunction

  // Textbook full-array expansion used as the reference schedule.
  task automatic build_ref();
    for (int t = 0; t < 16; t++) ref_w[t] = msg[t];
    for (int t = 16; t < 64; t++) begin
      ref_w[t] = (rotr(ref_w[t-2], 17) ^ rotr(ref_w[t-2], 19) ^ (ref_w[t-2] >> 10))
               + ref_w[t-7]
               + (rotr(ref_w[t-15], 7) ^ rotr(ref_w[t-15], 18) ^ (ref_w[t-15] >> 3))
               + ref_w[t-16];
    end
  endtask

  task automatic set_abc();
    for (int i = 0; i < 16; i++) msg[i] = 32'd0;
    msg[0]  = 32'h61626380;
    msg[15] = 32'h00000018;
    build_ref();
  endtask

  task automatic set_ones();
    for (int i = 0; i < 16; i++) msg[i] = 32'hFFFFFFFF;
    build_ref();
  endtask

  // Feed msg[0..15]; gap_mode inserts idle cycles between words.
  task automatic apply_stimulus(input bit gap_mode);
    for (int i = 0; i < 16; i++) begin
      if (gap_mode) begin
        for (int g = 0; g < (i % 3); g++) begin
          blk_valid = 1'b0;
          step();
        end
      end
      check_output("load_blk_ready", 32'(blk_ready), 32'd1);
      blk_valid = 1'b1;
      blk_word  = msg[i];
      step();
      if (i == 0) check_output("load_busy", 32'(busy), 32'd1);
    end
    blk_valid = 1'b0;
    blk_word  = 32'd0;
    check_output("first_latency_w_valid", 32'(w_valid), 32'd1);
  endtask

  // Consume schedule words up to (not including) stop_at, comparing against
  // ref_w; optionally stalls randomly and/or holds blk_valid high.
  task automatic collect_words(input bit stall, input bit hold_valid, input int stop_at,
                               input logic [31:0] w16_hand, input bit chk17,
                               input logic [31:0] w17_hand);
    int exp_idx;
    int budget;
    exp_idx = 0;
    budget  = 0;
    while (exp_idx < stop_at && budget < 2000) begin
      check_output("w_valid", 32'(w_valid), 32'd1);
      check_output("w_idx", 32'(w_idx), 32'(exp_idx));
      check_output("w_word", w_word, ref_w[exp_idx]);
      check_output("w_last", 32'(w_last), (exp_idx == 63) ? 32'd1 : 32'd0);
      check_output("emit_blk_ready", 32'(blk_ready), 32'd0);
      if (exp_idx == 16) check_output("w16_hand", w_word, w16_hand);
      if (exp_idx == 17 && chk17) check_output("w17_hand", w_word, w17_hand);
      w_ready   = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      blk_valid = hold_valid;
      blk_word  = 32'hDEADBEEF;
      step();
      if (w_ready) exp_idx++;
      budget++;
    end
    if (budget >= 2000) check_output("emit_timeout", 32'(exp_idx), 32'(stop_at));
    w_ready   = 1'b0;
    blk_valid = 1'b0;
    blk_word  = 32'd0;
    if (stop_at == 64) begin
      check_output("post_block_w_valid", 32'(w_valid), 32'd0);
      check_output("post_block_blk_ready", 32'(blk_ready), 32'd1);
      check_output("post_block_busy", 32'(busy), 32'd0);
      check_output("post_block_w_idx", 32'(w_idx), 32'd0);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check_output({tag, "_blk_ready"}, 32'(blk_ready), 32'd1);
    check_output({tag, "_w_valid"}, 32'(w_valid), 32'd0);
    check_output({tag, "_w_word"}, w_word, 32'd0);
    check_output({tag, "_w_idx"}, 32'(w_idx), 32'd0);
    check_output({tag, "_w_last"}, 32'(w_last), 32'd0);
    check_output({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  // Linear sequence of directed scenarios.
  initial begin
    errors    = 0;
    checks    = 0;
    rst       = 1'b1;
    blk_valid = 1'b0;
    blk_word  = 32'd0;
    w_ready   = 1'b0;

    $display("[TB] reset");
    step();
    step();
    rst = 1'b0;
    step();
    check_reset_state("reset");

    $display("[TB] abc block, no stalls");
    set_abc();
    apply_stimulus(1'b0);
    collect_words(1'b0, 1'b0, 64, 32'h61626380, 1'b1, 32'h000F0000);

    $display("[TB] all-ones block");
    set_ones();
    apply_stimulus(1'b0);
    collect_words(1'b0, 1'b0, 64, 32'h203FFFFC, 1'b0, 32'd0);

    $display("[TB] abc block, random stalls");
    set_abc();
    apply_stimulus(1'b0);
    collect_words(1'b1, 1'b0, 64, 32'h61626380, 1'b1, 32'h000F0000);

    $display("[TB] sparse load, blk_valid held during emit");
    set_ones();
    apply_stimulus(1'b1);
    collect_words(1'b0, 1'b1, 64, 32'h203FFFFC, 1'b0, 32'd0);
    set_abc();
    apply_stimulus(1'b1);
    collect_words(1'b1, 1'b1, 64, 32'h61626380, 1'b1, 32'h000F0000);

    $display("[TB] reset at idx 30");
    set_ones();
    apply_stimulus(1'b0);
    collect_words(1'b0, 1'b0, 30, 32'h203FFFFC, 1'b0, 32'd0);
    check_output("abort_w_idx", 32'(w_idx), 32'd30);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_reset_state("abort");
    step();
    check_reset_state("abort_post");
    set_abc();
    apply_stimulus(1'b0);
    collect_words(1'b0, 1'b0, 64, 32'h61626380, 1'b1, 32'h000F0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sha256_msg_sched.md
Name: sha256_msg_sched

Overview:
- SHA-256 message-schedule generator for the TRNG conditioning path.
- Accepts one 512-bit block as 16 serial 32-bit words and expands it to W[0..63].
- Emits one word per accepted handshake to the compression-round datapath, which feeds the round state through the Ch/Maj logic.
- Uses a 16-word sliding window: one adder tree and no 64-word storage.

Parameters:
- NUM_ROUNDS, 64, number of W words emitted per block; only 64 is supported.

Ports:
- clk  input  1  system clock, all logic rising-edge
- rst  input  1  synchronous, active-high reset
- blk_valid  input  1  blk_word is valid this cycle
- blk_ready  output  1  block accepts an input word this cycle
- blk_word  input  32  message word, big-endian, M[0] first
- w_valid  output  1  w_word/w_idx are valid
- w_ready  input  1  consumer takes w_word this cycle
- w_word  output  32  schedule word W[w_idx]
- w_idx  output  6  round index 0..63
- w_last  output  1  high while w_valid and w_idx==63
- busy  output  1  high whenever state != LOAD or load count != 0

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=LOAD, load count=0, emit index=0.
  - blk_ready=1, w_valid=0, w_word=0, w_idx=0, w_last=0, busy=0.
  - Window contents are don't-care.
  - Reset mid-load or mid-emit discards the partial block. The first cycle after reset is a clean LOAD.
- Window: win[0..15], where win[0] is the oldest word.
- LOAD state:
  - blk_ready=1, w_valid=0.
  - On blk_valid&blk_ready, blk_word shifts into win[15] and win[i] gets win[i+1]. The load count increments.
  - When the 16th word is accepted, the next state is EMIT with idx=0 and win[0]=M[0].
- EMIT state:
  - blk_ready=0, w_valid=1.
  - w_word = win[0], w_idx = idx, and both are registered outputs.
  - While w_valid & !w_ready, w_word, w_idx and w_last hold stable.
  - On w_valid&w_ready, the window shifts left by one and win[15] gets n:
    - n = s1(win[14]) + win[9] + s0(win[1]) + win[0], mod 2^32, carries discarded.
    - s0(x) = ROTR7(x) ^ ROTR18(x) ^ SHR3(x)
    - s1(x) = ROTR17(x) ^ ROTR19(x) ^ SHR10(x)
  - The first handshake produces W[16]. The new value is computed every handshake; values past W[63] are unused.
  - After the handshake with idx==63, the next state is LOAD: load count=0, w_valid=0, blk_ready=1 in the following cycle.
- Latency and throughput:
  - The first W word is valid on the cycle after the 16th input handshake.
  - Throughput is one W word per cycle when w_ready is held high.
  - Minimum block period is 16+64=80 cycles. There is no overlap of load and emit.
- blk_valid during EMIT is ignored (blk_ready=0); words are neither accepted nor lost.
- w_ready during LOAD is ignored.
- idx width is exactly 6 bits. No wrap is possible because the exit occurs at 63.
- There is no internal timeout. The consumer may stall indefinitely.

Test Plan:
1. Reset with rst=1 for 2 cycles -> blk_ready=1, w_valid=0, w_word=0, w_idx=0, busy=0 on the first cycle after release.
2. "abc" padded block: W0=0x61626380, W1..W14=0, W15=0x00000018, w_ready=1 -> W[0..15] echo the inputs, W16=0x61626380, W17=0x000F0000. Exactly 64 words are emitted with w_last only on idx 63, then blk_ready=1 the next cycle.
3. All 16 words 0xFFFFFFFF -> W16=0x203FFFFC, which checks the 32-bit wrap and both sigma functions.
4. Random stall on w_ready (about 50% duty) during the "abc" block -> the sequence is identical to scenario 2, and w_word/w_idx stay constant across every stalled cycle.
5. Sparse blk_valid during LOAD (gaps between words), plus blk_valid=1 held during EMIT -> only 16 words are accepted, and no extra word is absorbed during EMIT.
6. Assert rst at idx=30 of a block, then load a new "abc" block -> w_idx restarts at 0 and W16=0x61626380, with no residue from the aborted block.
